box_drawer: RTL and testbench



---
 rtl/game_pkg.sv | 27 ++
 rtl/box_pixel_counter.sv | 54 +++++
 rtl/box_drawer.sv | 139 +++++++++++++
 tb/tb_box_drawer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level constants and types: screen geometry, pixel bus widths,
// colour codes and the box drawer's state encoding.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

  // state    | meaning
  // BD_IDLE  | waiting for a game tick (or a tick collapsed while busy)
  // BD_ERASE | repainting the previous box position in background colour
  // BD_DRAW  | painting the box at the newly latched position
  // BD_DONE  | one-cycle completion pulse, current position becomes old
  typedef enum logic [1:0] {
    BD_IDLE  = 2'd0,
    BD_ERASE = 2'd1,
    BD_DRAW  = 2'd2,
    BD_DONE  = 2'd3
  } box_state_e;

endpackage

// File: rtl/box_pixel_counter.sv
// Raster scan counters for a BOX_SIZE x BOX_SIZE sprite: dx is the inner
// (column) counter, dy the outer (row) counter. Wraps to 0,0 after the
// last pixel so back-to-back scans need no explicit clear.
module box_pixel_counter #(
  parameter int BOX_SIZE = 4,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] dx,
  output logic [CNT_W-1:0] dy,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(BOX_SIZE - 1);

  logic [CNT_W-1:0] dx_q, dx_d;
  logic [CNT_W-1:0] dy_q, dy_d;

  // next raster position: column first, row on column wrap
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = '0;
      dy_d = '0;
    end else if (advance) begin
      if (dx_q == MAX_IDX) begin
        dx_d = '0;
        dy_d = (dy_q == MAX_IDX) ? '0 : dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == MAX_IDX) && (dy_q == MAX_IDX);

endmodule

// File: rtl/box_drawer.sv
// Redraws the player box once per game tick: erase the old position in the
// background colour, then draw the new one, one pixel per clock, driving the
// VGA adapter's plot interface. Rows below the screen are scanned but not
// plotted so every redraw takes the same number of cycles.
module box_drawer
  import game_pkg::*;
#(
  parameter int                  BOX_X      = 20,
  parameter int                  BOX_SIZE   = 4,
  parameter logic [COLOUR_W-1:0] BOX_COLOUR = COLOUR_WHITE,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = COLOUR_BLACK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                game_tick,
  input  logic [Y_W-1:0]      y_coordinate,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                frame_done
);

  localparam int CNT_W = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;

  box_state_e     state_q, state_d;
  logic [Y_W-1:0] new_y_q, new_y_d;
  logic [Y_W-1:0] old_y_q, old_y_d;
  logic           old_valid_q, old_valid_d;
  logic           pending_q, pending_d;

  logic             cnt_clear;
  logic             cnt_advance;
  logic [CNT_W-1:0] dx;
  logic [CNT_W-1:0] dy;
  logic             cnt_last;

  logic             scanning;
  logic [Y_W-1:0]   base_y;
  logic [Y_W:0]     row_sum;

  box_pixel_counter #(
    .BOX_SIZE (BOX_SIZE),
    .CNT_W    (CNT_W)
  ) u_pixel_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .dx      (dx),
    .dy      (dy),
    .last    (cnt_last)
  );

  // next-state, latches and counter control
  always_comb begin
    state_d     = state_q;
    new_y_d     = new_y_q;
    old_y_d     = old_y_q;
    old_valid_d = old_valid_q;
    pending_d   = pending_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;

    // ticks arriving mid-redraw collapse into a single follow-up frame
    if (game_tick && (state_q != BD_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      BD_IDLE: begin
        if (game_tick || pending_q) begin
          new_y_d   = y_coordinate;
          pending_d = 1'b0;
          cnt_clear = 1'b1;
          state_d   = old_valid_q ? BD_ERASE : BD_DRAW;
        end
      end
      BD_ERASE: begin
        cnt_advance = 1'b1;
        if (cnt_last) begin
          state_d = BD_DRAW;
        end
      end
      BD_DRAW: begin
        cnt_advance = 1'b1;
        if (cnt_last) begin
          state_d = BD_DONE;
        end
      end
      BD_DONE: begin
        old_y_d     = new_y_q;
        old_valid_d = 1'b1;
        state_d     = BD_IDLE;
      end
      default: begin
        state_d = BD_IDLE;
      end
    endcase
  end

  // state and position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BD_IDLE;
      new_y_q     <= '0;
      old_y_q     <= '0;
      old_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      new_y_q     <= new_y_d;
      old_y_q     <= old_y_d;
      old_valid_q <= old_valid_d;
      pending_q   <= pending_d;
    end
  end

  // Moore pixel decode; row sum is one bit wider so off-screen rows are visible
  always_comb begin
    scanning   = (state_q == BD_ERASE) || (state_q == BD_DRAW);
    base_y     = (state_q == BD_ERASE) ? old_y_q : new_y_q;
    row_sum    = {1'b0, base_y} + (Y_W + 1)'(dy);
    x_out      = X_W'(BOX_X);
    y_out      = '0;
    colour     = BG_COLOUR;
    plot       = 1'b0;
    busy       = (state_q != BD_IDLE);
    frame_done = (state_q == BD_DONE);
    if (scanning) begin
      x_out  = X_W'(BOX_X) + X_W'(dx);
      y_out  = row_sum[Y_W-1:0];
      colour = (state_q == BD_DRAW) ? BOX_COLOUR : BG_COLOUR;
      plot   = (row_sum < (Y_W + 1)'(SCREEN_H));
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// Directed bench for box_drawer: a table of whole-frame vectors checked
// pixel by pixel, plus hand-written sequences for collapsed ticks and
// resets arriving mid-frame or together with a tick.
module tb_box_drawer;

  localparam int BX = 20;
  localparam int BS = 4;
  localparam int NPIX = BS * BS;

  logic       clk = 1'b0;
  logic       reset;
  logic       game_tick;
  logic [6:0] y_coordinate;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int y;       // tick position
    bit erase;   // erase phase expected
    int old_y;   // position being erased
    int plots;   // plot=1 cycles expected in the frame
    int len;     // cycles from tick (inclusive) to frame_done (inclusive)
  } frame_vec_t;

  frame_vec_t vecs[5];

  box_drawer dut (
    .clk          (clk),
    .reset        (reset),
    .game_tick    (game_tick),
    .y_coordinate (y_coordinate),
    .x_out        (x_out),
    .y_out        (y_out),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Applies one tick and checks every cycle up to and after frame_done.
  task automatic run_frame(input frame_vec_t v, input string tag);
    int plots;
    int p;
    int base;
    int row;
    bit er;
    y_coordinate = 7'(v.y);
    game_tick    = 1'b1;
    @(negedge clk);
    chk({tag, " accept busy"}, int'(busy), 0);
    chk({tag, " accept plot"}, int'(plot), 0);
    next_cycle();
    game_tick = 1'b0;
    plots = 0;
    for (int k = 1; k < v.len; k++) begin
      @(negedge clk);
      chk({tag, " busy"}, int'(busy), 1);
      if (k == v.len - 1) begin
        chk({tag, " frame_done"}, int'(frame_done), 1);
        chk({tag, " done plot"}, int'(plot), 0);
      end else begin
        p  = k - 1;
        er = 1'b0;
        if (v.erase) begin
          if (p < NPIX) er = 1'b1;
          else p = p - NPIX;
        end
        base = er ? v.old_y : v.y;
        row  = base + p / BS;
        chk({tag, " frame_done early"}, int'(frame_done), 0);
        chk({tag, " x"}, int'(x_out), BX + p % BS);
        chk({tag, " y"}, int'(y_out), row % 128);
        chk({tag, " colour"}, int'(colour), er ? 0 : 7);
        chk({tag, " plot"}, int'(plot), (row <= 119) ? 1 : 0);
      end
      if (plot) plots++;
      next_cycle();
    end
    chk({tag, " plot count"}, plots, v.plots);
    @(negedge clk);
    chk({tag, " idle busy"}, int'(busy), 0);
    chk({tag, " idle frame_done"}, int'(frame_done), 0);
    next_cycle();
  endtask

  initial begin
    int done_cnt;
    int late_busy;
    int late_plot;
    frame_vec_t fv;

    vecs[0] = '{y: 60,  erase: 1'b0, old_y: 0,   plots: 16, len: 18};
    vecs[1] = '{y: 61,  erase: 1'b1, old_y: 60,  plots: 32, len: 34};
    vecs[2] = '{y: 118, erase: 1'b1, old_y: 61,  plots: 24, len: 34};
    vecs[3] = '{y: 116, erase: 1'b1, old_y: 118, plots: 24, len: 34};
    vecs[4] = '{y: 0,   erase: 1'b1, old_y: 116, plots: 32, len: 34};

    reset        = 1'b1;
    game_tick    = 1'b0;
    y_coordinate = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("reset x_out", int'(x_out), BX);
    chk("reset y_out", int'(y_out), 0);
    chk("reset colour", int'(colour), 0);
    chk("reset plot", int'(plot), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset frame_done", int'(frame_done), 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], $sformatf("frame%0d", i));
    end

    // Collapsed ticks while busy; position moves to 70 before DONE.
    done_cnt  = 0;
    late_busy = 0;
    late_plot = 0;
    for (int k = 0; k <= 80; k++) begin
      game_tick    = (k == 0 || k == 3 || k == 10 || k == 20);
      y_coordinate = (k >= 25) ? 7'd70 : 7'd20;
      @(negedge clk);
      if (frame_done) done_cnt++;
      if (k >= 68 && busy) late_busy++;
      if (k >= 68 && plot) late_plot++;
      if (k == 1) begin
        chk("pend erase first y", int'(y_out), 0);
        chk("pend erase first colour", int'(colour), 0);
        chk("pend erase first plot", int'(plot), 1);
      end
      if (k == 17) begin
        chk("pend draw y", int'(y_out), 20);
        chk("pend draw colour", int'(colour), 7);
      end
      if (k == 32) begin
        chk("pend last x", int'(x_out), 23);
        chk("pend last y", int'(y_out), 23);
      end
      if (k == 33) chk("pend frame_done 1", int'(frame_done), 1);
      if (k == 34) chk("pend idle gap busy", int'(busy), 0);
      if (k == 35) begin
        chk("pend2 busy", int'(busy), 1);
        chk("pend2 erase y", int'(y_out), 20);
        chk("pend2 erase colour", int'(colour), 0);
      end
      if (k == 51) begin
        chk("pend2 draw y", int'(y_out), 70);
        chk("pend2 draw colour", int'(colour), 7);
      end
      if (k == 67) chk("pend frame_done 2", int'(frame_done), 1);
      next_cycle();
    end
    game_tick = 1'b0;
    chk("pend frame count", done_cnt, 2);
    chk("pend no third busy", late_busy, 0);
    chk("pend no third plot", late_plot, 0);

    // Reset during the 5th DRAW cycle of an erase+draw frame.
    late_busy = 0;
    late_plot = 0;
    y_coordinate = 7'd30;
    for (int k = 0; k <= 27; k++) begin
      game_tick = (k == 0);
      reset     = (k == 21);
      @(negedge clk);
      if (k == 21) begin
        chk("rst mid plot before", int'(plot), 1);
        chk("rst mid y before", int'(y_out), 31);
        chk("rst mid colour before", int'(colour), 7);
      end
      if (k == 22) begin
        chk("rst mid plot after", int'(plot), 0);
        chk("rst mid busy after", int'(busy), 0);
      end
      if (k > 22 && busy) late_busy++;
      if (k > 22 && plot) late_plot++;
      next_cycle();
    end
    reset     = 1'b0;
    game_tick = 1'b0;
    chk("rst mid stays idle", late_busy, 0);
    chk("rst mid no plots", late_plot, 0);
    fv = '{y: 40, erase: 1'b0, old_y: 0, plots: 16, len: 18};
    run_frame(fv, "post_rst");

    // Tick coincident with reset must be dropped.
    late_busy = 0;
    late_plot = 0;
    reset        = 1'b1;
    game_tick    = 1'b1;
    y_coordinate = 7'd50;
    next_cycle();
    reset     = 1'b0;
    game_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy) late_busy++;
      if (plot) late_plot++;
      next_cycle();
    end
    chk("tick+rst busy", late_busy, 0);
    chk("tick+rst plot", late_plot, 0);
    fv = '{y: 50, erase: 1'b0, old_y: 0, plots: 16, len: 18};
    run_frame(fv, "after_tick_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
